// File: rtl/delta_sigma_decoder_if.sv
// Stream-in / sample-out bundle for delta_sigma_decoder; sync_i exists only
// when DELTA_SIGMA_DEC_SYNC_EN is defined.
interface delta_sigma_decoder_if #(
   parameter int INBITS  = 4,
   parameter int OUTBITS = 16
) ();
   logic [INBITS-1:0]  audio_i;
   logic [OUTBITS-1:0] sample_o;
   logic               valid_o;
   logic               ready_i;
   logic               overrun_o;
`ifdef DELTA_SIGMA_DEC_SYNC_EN
   logic               sync_i;

   modport master (
      input  audio_i,
      input  ready_i,
      input  sync_i,
      output sample_o,
      output valid_o,
      output overrun_o
   );

   modport slave (
      output audio_i,
      output ready_i,
      output sync_i,
      input  sample_o,
      input  valid_o,
      input  overrun_o
   );
`else
   modport master (
      input  audio_i,
      input  ready_i,
      output sample_o,
      output valid_o,
      output overrun_o
   );

   modport slave (
      output audio_i,
      output ready_i,
      input  sample_o,
      input  valid_o,
      input  overrun_o
   );
`endif
endinterface

// File: rtl/delta_sigma_decoder.sv
// Boxcar-integrates 2**(OUTBITS-INBITS) dithered stream words into one PCM sample.
// Defining DELTA_SIGMA_DEC_SYNC_EN adds the sync_i frame-realign strobe.
module delta_sigma_decoder #(
   parameter int INBITS  = 4,
   parameter int OUTBITS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   delta_sigma_decoder_if.master bus
);
   // Frame length is a power of two, so the phase counter is exactly PW bits wide.
   localparam int PW = OUTBITS - INBITS;
   localparam logic [PW-1:0] LAST_PHASE = {PW{1'b1}};

   logic [PW-1:0]      phase_q, phase_d;
   logic [OUTBITS-1:0] acc_q, acc_d;
   logic [OUTBITS-1:0] sample_q, sample_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic [OUTBITS-1:0] frame_sum_s;
   logic               frame_end_s;
   logic               sync_s;

`ifdef DELTA_SIGMA_DEC_SYNC_EN
   assign sync_s = bus.sync_i;
`else
   assign sync_s = 1'b0;
`endif

   // Framing: sync restarts the frame with this word as word 0 and suppresses any frame end.
   always_comb begin
      frame_sum_s = acc_q + OUTBITS'(bus.audio_i);
      frame_end_s = 1'b0;
      phase_d     = phase_q;
      acc_d       = acc_q;
      if (sync_s) begin
         phase_d = PW'(1'b1);
         acc_d   = OUTBITS'(bus.audio_i);
      end else if (phase_q == LAST_PHASE) begin
         phase_d     = {PW{1'b0}};
         acc_d       = {OUTBITS{1'b0}};
         frame_end_s = 1'b1;
      end else begin
         phase_d = phase_q + PW'(1'b1);
         acc_d   = frame_sum_s;
      end
   end

   // Single-entry output holding register with sticky drop flag.
   always_comb begin
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (frame_end_s) begin
         if (!valid_q || bus.ready_i) begin
            sample_d = frame_sum_s;
            valid_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= {PW{1'b0}};
         acc_q     <= {OUTBITS{1'b0}};
         sample_q  <= {OUTBITS{1'b0}};
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         acc_q     <= acc_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.sample_o  = sample_q;
   assign bus.valid_o   = valid_q;
   assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_delta_sigma_decoder.sv
// Directed bench for delta_sigma_decoder: frame-sum reference model plus literal checks.
module tb_delta_sigma_decoder;
   localparam int INB  = 4;
   localparam int OUTB = 16;
   localparam int N    = 1 << (OUTB - INB);
`ifdef DELTA_SIGMA_DEC_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   delta_sigma_decoder_if #(.INBITS(INB), .OUTBITS(OUTB)) bus ();
   delta_sigma_decoder #(.INBITS(INB), .OUTBITS(OUTB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int unsigned frame_words[$];
   logic [15:0] m_sample;
   logic        m_valid;
   logic        m_over;
   bit          cmp_en = 1'b0;
   logic [11:0] mod_err;
   logic [3:0]  w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      frame_words.delete();
      m_sample = 16'h0000;
      m_valid  = 1'b0;
      m_over   = 1'b0;
   endtask

   // Reference: a frame is the list of words since reset/sync; when it holds N words its sum is offered.
   task automatic model_step(input logic [3:0] a, input logic r, input logic s);
      int unsigned sum;
      bit fend;
      sum  = 0;
      fend = 1'b0;
      if (s) frame_words.delete();
      frame_words.push_back(int'(a));
      if (!s && frame_words.size() == N) begin
         foreach (frame_words[i]) sum += frame_words[i];
         fend = 1'b1;
         frame_words.delete();
      end
      if (fend) begin
         if (!m_valid || r) begin
            m_sample = sum[15:0];
            m_valid  = 1'b1;
         end else begin
            m_over = 1'b1;
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   // First-order LSB-dithering modulator used as the loopback source.
   task automatic mod_word(input logic [15:0] x, output logic [3:0] o);
      logic [12:0] s;
      s       = {1'b0, mod_err} + {1'b0, x[11:0]};
      mod_err = s[11:0];
      if (x[15:12] == 4'hF) o = 4'hF;
      else o = x[15:12] + {3'b000, s[12]};
   endtask

   task automatic cyc(input logic [3:0] a, input logic r, input logic s);
      bus.audio_i = a;
      bus.ready_i = r;
`ifdef DELTA_SIGMA_DEC_SYNC_EN
      bus.sync_i  = s;
`endif
      @(posedge clk);
      model_step(a, r, SYNC_ON ? s : 1'b0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset sample_o", bus.sample_o, 16'h0000);
      check("reset valid_o", bus.valid_o, 1'b0);
      check("reset overrun_o", bus.overrun_o, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model valid_o", bus.valid_o, m_valid);
         check("model overrun_o", bus.overrun_o, m_over);
         check("model sample_o", bus.sample_o, m_sample);
      end
   end

   initial begin
      bus.audio_i = 4'h0;
      bus.ready_i = 1'b0;
`ifdef DELTA_SIGMA_DEC_SYNC_EN
      bus.sync_i  = 1'b0;
`endif
      mod_err = 12'h000;
      model_reset();
      @(negedge clk);
      do_reset();
      cmp_en = 1'b1;

      // Constant 3: one pulse of 16'h3000 right after word N.
      for (int i = 0; i < N - 1; i++) cyc(4'h3, 1'b1, 1'b0);
      check("t1 no early valid", bus.valid_o, 1'b0);
      cyc(4'h3, 1'b1, 1'b0);
      check("t1 valid", bus.valid_o, 1'b1);
      check("t1 sample", bus.sample_o, 16'h3000);
      cyc(4'h3, 1'b1, 1'b0);
      check("t1 pulse width", bus.valid_o, 1'b0);

      // Modulator loopback at arbitrary phase.
      for (int i = 0; i < 3 * N; i++) begin
         mod_word(16'h1234, w);
         cyc(w, 1'b1, 1'b0);
      end
      check("t2 loopback 1234", bus.sample_o, 16'h1234);
      for (int i = 0; i < 2 * N; i++) begin
         mod_word(16'hFFFF, w);
         cyc(w, 1'b1, 1'b0);
      end
      check("t3 saturated FFFF", bus.sample_o, 16'hF000);
      for (int i = 0; i < 2 * N; i++) begin
         mod_word(16'h0001, w);
         cyc(w, 1'b1, 1'b0);
      end
      check("t3 loopback 0001", bus.sample_o, 16'h0001);

      // Back-pressure across two frame ends.
      do_reset();
      for (int i = 0; i < N; i++) cyc(4'h2, 1'b0, 1'b0);
      check("t4 first valid", bus.valid_o, 1'b1);
      check("t4 first sample", bus.sample_o, 16'h2000);
      check("t4 no overrun yet", bus.overrun_o, 1'b0);
      for (int i = 0; i < N; i++) cyc(4'h5, 1'b0, 1'b0);
      check("t4 sample held", bus.sample_o, 16'h2000);
      check("t4 overrun set", bus.overrun_o, 1'b1);
      check("t4 still valid", bus.valid_o, 1'b1);
      cyc(4'h5, 1'b1, 1'b0);
      check("t4 valid dropped", bus.valid_o, 1'b0);
      check("t4 overrun sticky", bus.overrun_o, 1'b1);

      // Reset mid-frame discards the partial sum.
      for (int i = 0; i < N - 1; i++) cyc(4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 2000; i++) cyc(4'hF, 1'b1, 1'b0);
      check("t5 overrun before reset", bus.overrun_o, 1'b1);
      do_reset();
      for (int i = 0; i < N - 1; i++) cyc(4'hF, 1'b1, 1'b0);
      check("t5 no early valid", bus.valid_o, 1'b0);
      cyc(4'hF, 1'b1, 1'b0);
      check("t5 valid", bus.valid_o, 1'b1);
      check("t5 sample", bus.sample_o, 16'hF000);

`ifdef DELTA_SIGMA_DEC_SYNC_EN
      // Realign at word 100, then a sync landing on a frame's last word.
      do_reset();
      for (int i = 0; i < 100; i++) cyc(4'h1, 1'b1, 1'b0);
      cyc(4'h1, 1'b1, 1'b1);
      for (int i = 0; i < N - 101; i++) cyc(4'h1, 1'b1, 1'b0);
      check("t6 no old-boundary output", bus.valid_o, 1'b0);
      for (int i = 0; i < 99; i++) cyc(4'h1, 1'b1, 1'b0);
      check("t6 no early valid", bus.valid_o, 1'b0);
      cyc(4'h1, 1'b1, 1'b0);
      check("t6 valid after sync frame", bus.valid_o, 1'b1);
      check("t6 sample after sync", bus.sample_o, 16'h1000);
      for (int i = 0; i < N - 1; i++) cyc(4'h2, 1'b1, 1'b0);
      cyc(4'h2, 1'b1, 1'b1);
      check("t6 frame end discarded", bus.valid_o, 1'b0);
      for (int i = 0; i < N - 1; i++) cyc(4'h3, 1'b1, 1'b0);
      check("t6 valid after resync", bus.valid_o, 1'b1);
      check("t6 sample after resync", bus.sample_o, 16'h2FFF);
`endif

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
